// File: rtl/ps2_key_event_ctrl.sv
// PS/2 Set 2 scancode sequencer: folds E0/F0/E1 prefix sequences into single key
// events, flags keyboard status bytes, and queues events in a show-ahead FIFO.
module ps2_key_event_ctrl #(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] scancode,
   input  logic       new_code,
   output logic [7:0] event_code,
   output logic       event_ext,
   output logic       event_break,
   output logic       event_valid,
   input  logic       event_ready,
   output logic       overflow,
   input  logic       clear_overflow,
   output logic       status_err,
   output logic       timeout_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_skip, w_skip_nxt;
   logic [WD_W-1:0]   r_wd;
   logic              w_push, w_status, w_timeout;
   logic [9:0]        w_push_data;
   logic              r_status, r_timeout, r_overflow;

   logic [9:0]        r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [9:0]        r_last;
   logic [9:0]        w_head, w_out;
   logic              w_empty, w_full, w_pop, w_wr, w_drop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_skip    <= 3'd0;
         r_status  <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_skip    <= w_skip_nxt;
         r_status  <= w_status;
         r_timeout <= w_timeout;
      end
   end

   // Event word layout: {ext, break, code}
   always_comb begin
      w_state_nxt = r_state;
      w_skip_nxt  = r_skip;
      w_push      = 1'b0;
      w_push_data = {2'b00, scancode};
      w_status    = 1'b0;
      w_timeout   = 1'b0;
      if (new_code) begin
         case (r_state)
            S_IDLE: begin
               case (scancode)
                  8'hE0: w_state_nxt = S_EXT;
                  8'hF0: w_state_nxt = S_BRK;
                  8'hE1: begin
                     w_state_nxt = S_PAUSE;
                     w_skip_nxt  = 3'd7;
                  end
                  8'hAA, 8'hFA, 8'hFE: ;
                  8'h00, 8'hFF, 8'hFC: w_status = 1'b1;
                  default: w_push = 1'b1;
               endcase
            end
            S_EXT: begin
               if (scancode == 8'hF0) begin
                  w_state_nxt = S_EXT_BRK;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_push      = (scancode != 8'h12);
                  w_push_data = {2'b10, scancode};
               end
            end
            S_BRK: begin
               w_state_nxt = S_IDLE;
               w_push      = 1'b1;
               w_push_data = {2'b01, scancode};
            end
            S_EXT_BRK: begin
               w_state_nxt = S_IDLE;
               w_push      = (scancode != 8'h12);
               w_push_data = {2'b11, scancode};
            end
            S_PAUSE: begin
               w_skip_nxt = r_skip - 3'd1;
               if (r_skip == 3'd1) begin
                  w_state_nxt = S_IDLE;
                  w_push      = 1'b1;
                  w_push_data = {2'b00, 8'hE1};
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (r_state != S_IDLE && r_wd == WD_LAST) begin
         // A byte arriving on the expiry cycle takes priority (handled above)
         w_state_nxt = S_IDLE;
         w_skip_nxt  = 3'd0;
         w_timeout   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_wd <= '0;
      else if (new_code || r_state == S_IDLE)
         r_wd <= '0;
      else
         r_wd <= r_wd + 1'b1;
   end

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   assign w_pop   = !w_empty && event_ready;
   assign w_wr    = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;
   assign w_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= w_push_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_pop)
            r_count <= r_count + 1'b1;
         else if (!w_wr && w_pop)
            r_count <= r_count - 1'b1;
         if (!w_empty)
            r_last <= w_head;
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clear_overflow)
            r_overflow <= 1'b0;
      end
   end

   // Once drained, the outputs keep showing the last head that was presented
   assign w_out       = w_empty ? r_last : w_head;
   assign event_ext   = w_out[9];
   assign event_break = w_out[8];
   assign event_code  = w_out[7:0];
   assign event_valid = !w_empty;
   assign overflow    = r_overflow;
   assign status_err  = r_status;
   assign timeout_err = r_timeout;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed scenarios plus random byte streams,
// compared cycle by cycle against a prefix-flag/queue reference model.
module tb_ps2_key_event_ctrl;

   localparam int DEPTH = 8;
   localparam int TO    = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] scancode = 8'h00;
   logic       new_code = 1'b0;
   logic       event_ready = 1'b0;
   logic       clear_overflow = 1'b0;
   logic [7:0] event_code;
   logic       event_ext, event_break, event_valid;
   logic       overflow, status_err, timeout_err;

   ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .scancode(scancode), .new_code(new_code),
      .event_code(event_code), .event_ext(event_ext), .event_break(event_break),
      .event_valid(event_valid), .event_ready(event_ready), .overflow(overflow),
      .clear_overflow(clear_overflow), .status_err(status_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending-prefix flags, pause bytes left, idle-edge count, event queue
   logic [9:0] m_q[$];
   bit         m_ext, m_brk, m_ovf, m_st, m_to;
   int         m_pause, m_wait;
   logic [9:0] m_last;

   task automatic model_reset();
      m_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_st = 0; m_to = 0;
      m_pause = 0; m_wait = 0; m_last = '0;
   endtask

   task automatic model_step();
      bit         push, pop, full, drop;
      logic [9:0] ev;
      push = 0;
      ev   = '0;
      pop  = (m_q.size() > 0) && event_ready;
      full = (m_q.size() == DEPTH);
      m_st = 0;
      m_to = 0;
      if (new_code) begin
         m_wait = 0;
         if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin push = 1; ev = {2'b00, 8'hE1}; end
         end else if (m_ext || m_brk) begin
            if (m_ext && !m_brk && scancode == 8'hF0) m_brk = 1;
            else begin
               if (!(m_ext && scancode == 8'h12)) begin push = 1; ev = {m_ext, m_brk, scancode}; end
               m_ext = 0; m_brk = 0;
            end
         end else begin
            case (scancode)
               8'hE0: m_ext = 1;
               8'hF0: m_brk = 1;
               8'hE1: m_pause = 7;
               8'hAA, 8'hFA, 8'hFE: ;
               8'h00, 8'hFF, 8'hFC: m_st = 1;
               default: begin push = 1; ev = {2'b00, scancode}; end
            endcase
         end
      end else if (m_ext || m_brk || m_pause > 0) begin
         if (m_wait == TO - 1) begin
            m_ext = 0; m_brk = 0; m_pause = 0; m_wait = 0; m_to = 1;
         end else m_wait++;
      end else m_wait = 0;
      drop = push && full && !pop;
      if (pop) void'(m_q.pop_front());
      if (push && !drop) m_q.push_back(ev);
      if (drop) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
   endtask

   task automatic check_outputs();
      check("event_valid", event_valid, (m_q.size() > 0));
      if (m_q.size() > 0) m_last = m_q[0];
      check("event_head", {event_ext, event_break, event_code}, m_last);
      check("overflow", overflow, m_ovf);
      check("status_err", status_err, m_st);
      check("timeout_err", timeout_err, m_to);
   endtask

   task automatic cycle(input bit nc, input logic [7:0] b);
      new_code = nc;
      scancode = b;
      @(posedge clk);
      if (reset_n) model_step();
      else model_reset();
      @(negedge clk);
      new_code = 1'b0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 8'h00);
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      cycle(1, b);
      idle(gap);
   endtask

   logic [7:0] special [10] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'hFC};
   logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

   initial begin
      model_reset();
      #1;
      check("rst_valid", event_valid, 1'b0);
      check("rst_code", event_code, 8'h00);
      check("rst_ext_brk", {event_ext, event_break}, 2'b00);
      check("rst_flags", {overflow, status_err, timeout_err}, 3'b000);
      @(negedge clk);
      idle(2);
      reset_n = 1'b1;
      event_ready = 1'b1;

      // Make / break / extended / fake shift
      send(8'h1C, 2); send(8'hF0, 0); send(8'h1C, 2);
      send(8'hE0, 0); send(8'h75, 2);
      send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 2);
      send(8'hE0, 0); send(8'h12, 2);

      // Pause, silent bytes, status error
      foreach (pause_seq[i]) send(pause_seq[i], 0);
      idle(2);
      send(8'hAA, 1); send(8'hFA, 1); send(8'hFF, 2);

      // Watchdog aborts a break prefix and a pause sequence
      send(8'hF0, 0); idle(TO + 4); send(8'h1C, 2);
      send(8'hE1, 3); idle(TO + 2); send(8'h14, 2);

      // Overflow, in-order drain, clear
      event_ready = 1'b0;
      for (int i = 1; i <= 9; i++) send(8'(i), 0);
      idle(2);
      event_ready = 1'b1;
      idle(DEPTH + 2);
      clear_overflow = 1'b1;
      cycle(0, 8'h00);
      clear_overflow = 1'b0;
      idle(2);

      // Full FIFO with simultaneous push and pop
      event_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(8'(8'h30 + i), 0);
      event_ready = 1'b1;
      send(8'h40, 0);
      event_ready = 1'b0;
      idle(2);
      event_ready = 1'b1;
      idle(DEPTH + 2);

      // Asynchronous reset mid-sequence
      event_ready = 1'b0;
      send(8'h1C, 1);
      send(8'hE0, 0);
      reset_n = 1'b0;
      #1;
      check("rst_mid_valid", event_valid, 1'b0);
      model_reset();
      @(negedge clk);
      idle(2);
      reset_n = 1'b1;
      event_ready = 1'b1;
      send(8'h1C, 2);

      // Random byte streams
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] b;
         event_ready    = ($urandom_range(0, 3) != 0);
         clear_overflow = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 99) < 40) b = special[$urandom_range(0, 9)];
         else b = 8'($urandom);
         if ($urandom_range(0, 59) == 0) idle(TO + $urandom_range(0, 3));
         cycle(($urandom_range(0, 2) == 0), b);
      end
      clear_overflow = 1'b0;
      event_ready = 1'b1;
      idle(DEPTH + 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sits directly downstream of the PS/2 byte receiver. Consumes its scancode/new_code byte stream (Set 2).
- Sequences multi-byte make/break/extended prefixes and the Pause sequence into single key events.
- Filters keyboard status bytes and buffers events in a small FIFO with a valid/ready interface to game/UI logic.
- Includes a prefix watchdog, so a lost byte cannot leave the decoder stuck mid-sequence.

Parameters:
- DEPTH, 8, event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one multi-byte sequence (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- scancode  input  8  byte from the PS/2 receiver; valid only when new_code=1
- new_code  input  1  one-cycle strobe, one byte per pulse
- event_code  output  8  FIFO head: base scancode (0xE1 for Pause)
- event_ext  output  1  FIFO head: 0xE0 prefix was seen
- event_break  output  1  FIFO head: key release (0xF0 prefix)
- event_valid  output  1  FIFO not empty
- event_ready  input  1  consumer accepts the head this cycle
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- clear_overflow  input  1  synchronous clear of overflow
- status_err  output  1  one-cycle pulse on byte 0x00, 0xFF or 0xFC (keyboard error)
- timeout_err  output  1  one-cycle pulse when the watchdog aborts a sequence

Behaviour:
- Reset (async):
  - Decoder goes to IDLE; FIFO is emptied.
  - event_code=0x00, event_ext=0, event_break=0, event_valid=0.
  - overflow=0, status_err=0, timeout_err=0; watchdog count=0.
- Decoder FSM advances only on new_code=1.
- Decoder states: IDLE, EXT (0xE0 seen), BRK (0xF0 seen), EXT_BRK (E0 F0 seen), PAUSE_SKIP.
- IDLE transitions:
  - 0xE0 -> EXT.
  - 0xF0 -> BRK.
  - 0xE1 -> PAUSE_SKIP with skip counter=7.
  - 0xAA (BAT OK), 0xFA (ACK), 0xFE (resend): discarded silently.
  - 0x00/0xFF/0xFC: status_err pulse next cycle; stay IDLE.
  - Any other byte b: push {ext=0, brk=0, b}; stay IDLE.
- EXT transitions:
  - 0xF0 -> EXT_BRK.
  - 0x12 (fake shift): discarded -> IDLE.
  - Other byte b: push {1, 0, b} -> IDLE.
- BRK: byte b -> push {0, 1, b} -> IDLE.
- EXT_BRK:
  - 0x12: discarded -> IDLE.
  - Other byte b: push {1, 1, b} -> IDLE.
- PAUSE_SKIP: each byte decrements the skip counter. After the 7th byte, push {0, 0, 0xE1} -> IDLE. Byte contents are not checked.
- A prefix byte received while already in EXT/BRK/EXT_BRK is treated as the data byte (no nesting).
- Push timing:
  - The push lands in the FIFO on the same clk edge that samples new_code.
  - event_valid rises the following cycle; decode latency is 1 cycle.
- Watchdog:
  - Counter clears on every new_code and whenever the FSM is IDLE; otherwise it increments.
  - When the count reaches TIMEOUT_CYCLES-1 in a non-IDLE state: FSM -> IDLE, skip counter cleared, timeout_err pulses for 1 cycle, nothing is pushed.
  - If new_code arrives on the same cycle the count expires, new_code wins: the byte is decoded normally and there is no timeout.
- FIFO:
  - Show-ahead: event_code/ext/break reflect the head whenever event_valid=1. Outputs hold their last value when empty.
  - Pop when event_valid && event_ready.
  - Push and pop in the same cycle are both performed; this includes the full case, where occupancy stays at DEPTH and nothing is lost.
  - Push while full with no pop: event dropped, overflow=1 from the next cycle, FIFO contents unchanged.
  - Pop when empty: ignored.
  - Read/write pointers wrap modulo DEPTH; occupancy counter is clog2(DEPTH)+1 bits.
- overflow:
  - Cleared by clear_overflow=1 on the next edge.
  - If a drop and clear_overflow occur in the same cycle, set wins.
- The consumer may hold event_ready=1 permanently; sustained throughput is 1 event per byte.

Test Plan:
- Bytes 0x1C; then 0xF0, 0x1C (ready=1) -> events {0x1C,0,0} then {0x1C,0,1}; each event_valid high exactly 1 cycle, 1 cycle after the final byte.
- 0xE0 0x75; 0xE0 0xF0 0x75; 0xE0 0x12 -> events {0x75,1,0}, {0x75,1,1}; no event for 0x12.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {0xE1,0,0}; 0xAA and 0xFA produce no event; 0xFF produces a status_err pulse.
- 0xF0 then no byte for TIMEOUT_CYCLES (set to 16) -> timeout_err pulses once, no event. A following 0x1C yields a make event, not a break.
- event_ready=0, DEPTH=8, send 9 makes 0x01..0x09 -> 8 buffered, overflow=1. Draining yields 0x01..0x08 in order. clear_overflow returns overflow to 0.
- FIFO full with push and pop in the same cycle -> no overflow; occupancy stays 8. reset_n asserted mid-sequence (after 0xE0) -> event_valid=0 immediately; next 0x1C decodes as a non-extended make.
